// File: rtl/hbi2.sv
// Polyphase half-band interpolate-by-2 filter: one input sample yields phase A
// (FIR of the 4-deep input history) then phase B (delayed input), with valid/ready on both sides.
module hbi2 #(
  parameter int DW    = 33,
  parameter int CW    = 16,
  parameter int SHIFT = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in,
  input  logic          valid_in,
  output logic          in_ready,
  output logic [DW-1:0] out,
  output logic          valid_out,
  input  logic          ready_out
);

  localparam int W = DW + CW + 3;

  localparam logic signed [CW-1:0] B0 = -16'sd2761;
  localparam logic signed [CW-1:0] B2 = 16'sd10053;
  localparam logic signed [W-1:0]  B0_W = W'(B0);
  localparam logic signed [W-1:0]  B2_W = W'(B2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_A = 2'd1,
    HOLD_B = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic [DW-1:0]        d0_r, d1_r, d2_r;
  logic signed [DW:0]   pre0_s, pre1_s;
  logic signed [W-1:0]  acc_s, scaled_s;
  logic [DW-1:0]        phase_a_s;
  logic                 accept_s;
  logic [DW-1:0]        out_nxt_s;
  logic                 valid_nxt_s;

  // Clamp a full-width result into the DW-bit signed range.
  function automatic logic [DW-1:0] sat(input logic signed [W-1:0] v);
    if ((&v[W-1:DW-1]) || (~|v[W-1:DW-1])) begin
      sat = v[DW-1:0];
    end else if (v[W-1]) begin
      sat = {1'b1, {(DW-1){1'b0}}};
    end else begin
      sat = {1'b0, {(DW-1){1'b1}}};
    end
  endfunction

  assign in_ready = (state_r == IDLE) || ((state_r == HOLD_B) && ready_out);
  assign accept_s = valid_in && in_ready;

  // Phase A uses the incoming sample and the pre-shift history; the x2 gain folds into SHIFT.
  assign pre0_s    = {in[DW-1], in} + {d2_r[DW-1], d2_r};
  assign pre1_s    = {d0_r[DW-1], d0_r} + {d1_r[DW-1], d1_r};
  assign acc_s     = W'(pre0_s) * B0_W + W'(pre1_s) * B2_W;
  assign scaled_s  = acc_s >>> SHIFT;
  assign phase_a_s = sat(scaled_s);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Input delay line, shifted only on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      d0_r <= {DW{1'b0}};
      d1_r <= {DW{1'b0}};
      d2_r <= {DW{1'b0}};
    end else if (accept_s) begin
      d0_r <= in;
      d1_r <= d0_r;
      d2_r <= d1_r;
    end else begin
      d0_r <= d0_r;
      d1_r <= d1_r;
      d2_r <= d2_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = HOLD_A;
        else          state_nxt_s = IDLE;
      end
      HOLD_A: begin
        if (ready_out) state_nxt_s = HOLD_B;
        else           state_nxt_s = HOLD_A;
      end
      HOLD_B: begin
        if (ready_out && accept_s) state_nxt_s = HOLD_A;
        else if (ready_out)        state_nxt_s = IDLE;
        else                       state_nxt_s = HOLD_B;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output next values; phase B is d1 after the acceptance shift, i.e. x[m-1].
  always_comb begin
    out_nxt_s   = out;
    valid_nxt_s = valid_out;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          out_nxt_s   = phase_a_s;
          valid_nxt_s = 1'b1;
        end else begin
          valid_nxt_s = 1'b0;
        end
      end
      HOLD_A: begin
        if (ready_out) begin
          out_nxt_s   = d1_r;
          valid_nxt_s = 1'b1;
        end else begin
          out_nxt_s   = out;
          valid_nxt_s = 1'b1;
        end
      end
      HOLD_B: begin
        if (ready_out && accept_s) begin
          out_nxt_s   = phase_a_s;
          valid_nxt_s = 1'b1;
        end else if (ready_out) begin
          valid_nxt_s = 1'b0;
        end else begin
          valid_nxt_s = 1'b1;
        end
      end
      default: begin
        out_nxt_s   = {DW{1'b0}};
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= {DW{1'b0}};
      valid_out <= 1'b0;
    end else begin
      out       <= out_nxt_s;
      valid_out <= valid_nxt_s;
    end
  end

endmodule

// File: tb/tb_hbi2.sv
// Bench for hbi2: directed spec scenarios plus randomized traffic, all checked
// against an arithmetic reference of the interpolator kept in a scoreboard queue.
module tb_hbi2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [32:0] din = 33'd0;
  logic        valid_in = 1'b0;
  logic        in_ready;
  logic [32:0] dout;
  logic        valid_out;
  logic        ready_out = 1'b0;

  int total = 0;
  int bad   = 0;
  bit stream_chk = 1'b0;

  longint exp_q[$];
  longint obs_q[$];
  longint hist[0:2] = '{64'sd0, 64'sd0, 64'sd0};

  localparam longint SMAX = 64'sd4294967295;
  localparam longint SMIN = -64'sd4294967296;

  hbi2 dut (
    .clk(clk), .rst(rst), .in(din), .valid_in(valid_in), .in_ready(in_ready),
    .out(dout), .valid_out(valid_out), .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [32:0] v);
    return longint'($signed(v));
  endfunction

  // y[2m] = sat(floor(2*(b0*(x[m]+x[m-3]) + b2*(x[m-1]+x[m-2])) / 2^15))
  function automatic longint ref_a(input longint x0, input longint x1, input longint x2, input longint x3);
    longint s;
    s = 2 * (-64'sd2761 * (x0 + x3) + 64'sd10053 * (x1 + x2));
    s = s >>> 15;
    if (s > SMAX) s = SMAX;
    if (s < SMIN) s = SMIN;
    return s;
  endfunction

  task automatic model_accept(input longint x);
    exp_q.push_back(ref_a(x, hist[0], hist[1], hist[2]));
    exp_q.push_back(hist[0]);
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = x;
  endtask

  // Scoreboard: every output transfer is compared to the model, every acceptance feeds it.
  initial begin
    longint e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        hist = '{64'sd0, 64'sd0, 64'sd0};
      end else begin
        if (valid_out && ready_out) begin
          obs_q.push_back(sx(dout));
          if (exp_q.size() == 0) begin
            check("sb_unexpected_out", sx(dout), 64'sd999999999999);
          end else begin
            e = exp_q.pop_front();
            check("sb_out", sx(dout), e);
          end
        end
        if (valid_in && in_ready) model_accept(sx(din));
        if (stream_chk) check("valid_cont", valid_out, 1);
      end
    end
  end

  task automatic reset_dut();
    rst = 1'b1; valid_in = 1'b0; ready_out = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    check("rst_valid", valid_out, 0);
    check("rst_out", sx(dout), 0);
    check("rst_ready", in_ready, 1);
    obs_q.delete();
  endtask

  task automatic send(input logic [32:0] x);
    int n;
    bit acc;
    valid_in = 1'b1; din = x; ready_out = 1'b1; n = 0; acc = 1'b0;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0; ready_out = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic impulse_run(input string tag);
    longint imp[16];
    imp = '{-64'sd5522, 64'sd0, 64'sd20106, 64'sd32768, 64'sd20106, 64'sd0, -64'sd5522, 64'sd0,
            64'sd0, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 64'sd0};
    obs_q.delete();
    send(33'd32768);
    stream_chk = 1'b1;
    for (int i = 0; i < 7; i++) send(33'd0);
    stream_chk = 1'b0;
    idle(4);
    check({tag, "_count"}, obs_q.size(), 16);
    for (int i = 0; i < 16 && i < obs_q.size(); i++) check(tag, obs_q[i], imp[i]);
  endtask

  function automatic logic [32:0] rnd33();
    logic [63:0] r;
    longint s;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 4))
      0: return 33'h0_FFFF_FFFF;
      1: return 33'h1_0000_0000;
      2: begin s = longint'($urandom_range(0, 65535)) - 64'sd32768; return s[32:0]; end
      default: return r[32:0];
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hold;
    reset_dut();

    // Impulse response with continuous streaming.
    impulse_run("impulse");
    check("impulse_drain", exp_q.size(), 0);

    // DC gain.
    reset_dut();
    for (int i = 0; i < 8; i++) send(33'd32768);
    idle(4);
    check("dc_count", obs_q.size(), 16);
    for (int i = 6; i < 16 && i < obs_q.size(); i++)
      check("dc", obs_q[i], (i % 2 == 0) ? 64'sd29168 : 64'sd32768);

    // Saturation on the fourth sample.
    reset_dut();
    send(33'h1_0000_0000);
    send(33'h0_FFFF_FFFF);
    send(33'h0_FFFF_FFFF);
    send(33'h1_0000_0000);
    idle(4);
    check("sat_count", obs_q.size(), 8);
    if (obs_q.size() == 8) begin
      check("sat_a", obs_q[6], SMAX);
      check("sat_b", obs_q[7], SMAX);
    end

    // Backpressure in HOLD_A with a new sample waiting.
    reset_dut();
    send(33'd100);
    ready_out = 1'b0; valid_in = 1'b1; din = 33'd777;
    repeat (5) begin
      @(negedge clk);
      check("bp_out", sx(dout), ref_a(100, 0, 0, 0));
      check("bp_valid", valid_out, 1);
      check("bp_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    send(33'd777);
    idle(4);
    check("bp_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      check("bp_seq_a0", obs_q[0], ref_a(100, 0, 0, 0));
      check("bp_seq_b0", obs_q[1], 0);
      check("bp_seq_a1", obs_q[2], ref_a(777, 100, 0, 0));
      check("bp_seq_b1", obs_q[3], 100);
    end

    // Reset during HOLD_B, then a clean impulse.
    reset_dut();
    send(33'd5);
    send(33'd6);
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_out", sx(dout), 0);
    check("mid_rst_ready", in_ready, 1);
    impulse_run("post_rst_impulse");

    // Gapped input every 5 cycles.
    reset_dut();
    for (int k = 0; k < 6; k++) begin
      send(rnd33());
      valid_in = 1'b0;
      check("gap_a_valid", valid_out, 1);
      @(posedge clk); #1;
      check("gap_b_valid", valid_out, 1);
      for (int j = 0; j < 3; j++) begin
        @(posedge clk); #1;
        check("gap_idle_valid", valid_out, 0);
      end
    end
    check("gap_drain", exp_q.size(), 0);

    // Random traffic with random backpressure; source holds data until accepted.
    reset_dut();
    hold = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!hold) begin
        valid_in = ($urandom_range(0, 3) != 0);
        din = rnd33();
      end
      ready_out = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      hold = valid_in && !in_ready;
      @(posedge clk); #1;
    end
    idle(6);
    check("rand_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hbi2.md
# hbi2

Half-band interpolate-by-2 filter for the DSM reconstruction path. It accepts 33-bit samples at the low rate and emits two 33-bit samples per input. It is the interpolating counterpart of the chain's 7-tap half-band decimator and uses the same Q1.15 coefficient set (b0 = -2761, b2 = 10053, b3 = 16384; b1 = b5 = 0). It is polyphase, with valid/ready handshakes on both sides so it can sit between a sample source and a rate-expanding stage or modulator that applies backpressure.

## Interface
Parameters:
- DW, 33, input/output sample width (two's complement)
- CW, 16, coefficient width (Q1.15)
- SHIFT, 14, output right-shift (Q1.15 scaling combined with the interpolation gain of 2)

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in  input  DW  input sample x[m], signed
- valid_in  input  1  in is valid
- in_ready  output  1  block accepts in this cycle
- out  output  DW  output sample y[n], signed, registered
- valid_out  output  1  out is valid, registered
- ready_out  input  1  downstream accepts out this cycle

## Operation
- Input delay line d0..d3 (DW each); d0 = newest x[m].
- Input acceptance occurs when valid_in && in_ready. On acceptance, the line shifts d0<=in, d1<=d0, d2<=d1, d3<=d2.
- Phase A, y[2m]:
  - sat((b0*(in + d2_old) + b2*(d0_old + d1_old)) * 2 >>> 15), using pre-shift values.
  - This equals b0*(x[m]+x[m-3]) + b2*(x[m-1]+x[m-2]), scaled by 2.
  - Implement as a single arithmetic >>> SHIFT.
  - Pre-add operands are DW+1 bits. Products and the sum are carried at full width, at least DW+CW+2 bits, with no intermediate truncation.
- Phase B, y[2m+1]:
  - x[m-1] * b3 * 2 >>> 15, which equals x[m-1] exactly.
  - Output d1 after the shift; no multiplier is required.
- sat(): clamp to [-2^(DW-1), 2^(DW-1)-1]. Arithmetic shift truncates toward minus infinity.
- FSM states:
  - IDLE: valid_out=0, in_ready=1. On acceptance: out<=A, valid_out<=1, go to HOLD_A.
  - HOLD_A: out holds A. If ready_out: out<=B, go to HOLD_B. Otherwise hold.
  - HOLD_B: out holds B. If ready_out and an input is accepted in the same cycle: out<=A of the new sample, valid_out stays 1, go to HOLD_A. If ready_out and no input: valid_out<=0, go to IDLE. Otherwise hold.
- in_ready = (state==IDLE) || (state==HOLD_B && ready_out). This is combinational from ready_out and is the only combinational path.
- While valid_out=1, out and valid_out are stable until ready_out. Output order is always A then B per input sample.

## Timing
- Reset: state=IDLE, d0..d3=0, out=0, valid_out=0, in_ready=1 (deasserted only after reset releases and an input is accepted).
- Latency: A appears on out in the cycle after acceptance. B appears in the cycle after A is accepted.
- Sustained throughput with ready_out held high: one input per 2 cycles, two outputs per 2 cycles, so valid_out stays continuously high.
- valid_in while in_ready=0: the sample is not consumed; the source must hold it.
- rst asserted mid-operation (HOLD_A or HOLD_B): pending outputs are dropped, the delay line is cleared, and the FSM returns to IDLE on the next edge.
- Saturation has no sticky flag; each sample is clamped independently.

## Test plan
- Impulse: in = 32768 then zeros, ready_out=1.
  - Out sequence: -5522, 0, 20106, 32768, 20106, 0, -5522, 0, then zeros.
  - valid_out is high continuously once input streaming starts.
- DC: constant in = 32768, ready_out=1.
  - After the fourth input, outputs alternate A=29168, B=32768 indefinitely.
- Saturation: inputs -2^32, 2^32-1, 2^32-1, -2^32.
  - The A produced by the fourth input equals 4294967295, clamped, not wrapped.
  - Its B equals 4294967295.
- Backpressure: hold ready_out=0 for 5 cycles in HOLD_A with valid_in=1 and a new sample presented.
  - out stays at A, in_ready=0, and the delay line is unchanged.
  - Raising ready_out produces B, then the presented sample is accepted in HOLD_B.
- Mid-operation reset: assert rst for 1 cycle during HOLD_B.
  - Next cycle: valid_out=0, out=0, in_ready=1.
  - A subsequent impulse reproduces the impulse sequence from its start, with no residue from earlier samples.
- Gapped input: valid_in pulses every 5 cycles, ready_out=1.
  - Each input yields exactly A then B on consecutive cycles, followed by valid_out=0 until the next input.
